seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/pa_fpu_pkg.sv | 17 +
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu_pkg.sv
// Shared FPU package: state encodings and small helpers used across FPU datapath blocks.
package pa_fpu;

  // Sequential restoring divider states (prefixed DIV_ to stay clear of e_div_st members).
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_LOAD = 2'd1,
    DIV_ITER = 2'd2,
    DIV_DONE = 2'd3
  } e_sdiv_st;

  // Bits needed to hold an iteration count from 0 up to n inclusive.
  function automatic int sdiv_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
// Purely combinational; relies on the incoming partial remainder being below the divisor.
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // With rem < divisor the WIDTH+1-bit difference's MSB is a reliable borrow flag.
  always_comb begin
    shifted  = {rem, shift_in};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential divider, quotient = (dividend << FRAC_BITS) / divisor; valid N+2 edges after start (2 on /0).
// No queueing: start honoured only while ready; result held until ack. SEQ_DIV_STICKY_EN adds the sticky port.
module seq_divider
  import pa_fpu::*;
#(
  parameter int WIDTH     = 24,
  parameter int FRAC_BITS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           dividend,
  input  logic [WIDTH-1:0]           divisor,
  output logic                       ready,
  output logic [WIDTH+FRAC_BITS-1:0] quotient,
  output logic [WIDTH-1:0]           remainder,
  output logic                       div_zero,
  output logic                       valid,
  input  logic                       ack
`ifdef SEQ_DIV_STICKY_EN
  ,
  output logic                       sticky
`endif
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = sdiv_cnt_w(N);

  e_sdiv_st         state;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [N-1:0]     sr_r;
  logic [CW-1:0]    cnt_r;
  logic             dz_r;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .shift_in (sr_r[N-1]),
    .divisor  (dsr_r),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      cnt_r     <= '0;
      dvd_r     <= '0;
      dsr_r     <= '0;
      rem_r     <= '0;
      sr_r      <= '0;
      dz_r      <= 1'b0;
`ifdef SEQ_DIV_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            dvd_r <= dividend;
            dsr_r <= divisor;
            ready <= 1'b0;
            state <= DIV_LOAD;
          end
        end
        DIV_LOAD: begin
          cnt_r <= CW'(N);
          // Divide-by-zero skips iteration: all-ones quotient, dividend passed through as remainder.
          if (dsr_r == '0) begin
            dz_r  <= 1'b1;
            rem_r <= dvd_r;
            sr_r  <= '1;
            state <= DIV_DONE;
          end else begin
            dz_r  <= 1'b0;
            rem_r <= '0;
            sr_r  <= N'(dvd_r) << FRAC_BITS;
            state <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          rem_r <= step_rem;
          sr_r  <= {sr_r[N-2:0], step_q};
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == CW'(1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          // First DONE cycle publishes the result; afterwards it is frozen until ack.
          if (!valid) begin
            valid     <= 1'b1;
            quotient  <= sr_r;
            remainder <= rem_r;
            div_zero  <= dz_r;
`ifdef SEQ_DIV_STICKY_EN
            sticky    <= (|rem_r) & ~dz_r;
`endif
          end else if (ack) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: fixed vectors on 8-bit instances, corner sequences, randomised 24/24 run vs arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  dvd8 = '0, dsr8 = '0;
  logic [23:0] dvd24 = '0, dsr24 = '0;

  logic        ready_a, valid_a, dz_a;
  logic [7:0]  q_a, r_a;
  logic        ready_b, valid_b, dz_b;
  logic [11:0] q_b;
  logic [7:0]  r_b;
  logic        ready_c, valid_c, dz_c;
  logic [47:0] q_c;
  logic [23:0] r_c;
`ifdef SEQ_DIV_STICKY_EN
  logic        stk_a, stk_b, stk_c;
`endif

  seq_divider #(.WIDTH(8), .FRAC_BITS(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dividend(dvd8), .divisor(dsr8),
    .ready(ready_a), .quotient(q_a), .remainder(r_a), .div_zero(dz_a),
    .valid(valid_a), .ack(ack)
`ifdef SEQ_DIV_STICKY_EN
    , .sticky(stk_a)
`endif
  );

  seq_divider #(.WIDTH(8), .FRAC_BITS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dividend(dvd8), .divisor(dsr8),
    .ready(ready_b), .quotient(q_b), .remainder(r_b), .div_zero(dz_b),
    .valid(valid_b), .ack(ack)
`ifdef SEQ_DIV_STICKY_EN
    , .sticky(stk_b)
`endif
  );

  seq_divider #(.WIDTH(24), .FRAC_BITS(24)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dividend(dvd24), .divisor(dsr24),
    .ready(ready_c), .quotient(q_c), .remainder(r_c), .div_zero(dz_c),
    .valid(valid_c), .ack(ack)
`ifdef SEQ_DIV_STICKY_EN
    , .sticky(stk_c)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int inst);
    case (inst)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic vld(input int inst);
    case (inst)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Reference: plain arithmetic on the scaled dividend.
  task automatic ref_div(input int w, input int f, input logic [63:0] dvd, input logic [63:0] dsr,
                         output logic [63:0] q, output logic [63:0] r, output logic dz, output logic stk);
    logic [63:0] ones;
    ones = '1;
    if (dsr == 0) begin
      q   = ones >> (64 - (w + f));
      r   = dvd;
      dz  = 1'b1;
      stk = 1'b0;
    end else begin
      q   = (dvd << f) / dsr;
      r   = (dvd << f) % dsr;
      dz  = 1'b0;
      stk = (r != 0);
    end
  endtask

  // One full transaction: wait ready, pulse start, count edges to valid, capture, ack.
  task automatic do_op(input int inst, input logic [23:0] dvd, input logic [23:0] dsr,
                       output logic [63:0] q, output logic [63:0] r, output logic dz,
                       output logic stk, output int lat);
    int w;
    w = 0;
    while (!rdy(inst) && w < 200) begin @(posedge clk); #1; w++; end
    if (inst == 2) begin dvd24 = dvd; dsr24 = dsr; end
    else begin dvd8 = dvd[7:0]; dsr8 = dsr[7:0]; end
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    lat = 0;
    while (!vld(inst) && lat < 200) begin @(posedge clk); #1; lat++; end
    stk = 1'b0;
    case (inst)
      0: begin q = 64'(q_a); r = 64'(r_a); dz = dz_a;
`ifdef SEQ_DIV_STICKY_EN
         stk = stk_a;
`endif
         end
      1: begin q = 64'(q_b); r = 64'(r_b); dz = dz_b;
`ifdef SEQ_DIV_STICKY_EN
         stk = stk_b;
`endif
         end
      default: begin q = 64'(q_c); r = 64'(r_c); dz = dz_c;
`ifdef SEQ_DIV_STICKY_EN
         stk = stk_c;
`endif
         end
    endcase
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  dvd;
    logic [7:0]  dsr;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        stk;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] q, r, eq, er;
    logic        dz, stk, edz, estk;
    int          lat;
    logic [23:0] rd, rs;

    tbl[0]  = '{0, 8'd100, 8'd7,   64'd14,    64'd2,   1'b0, 1'b1, 10};
    tbl[1]  = '{0, 8'd55,  8'd0,   64'hFF,    64'd55,  1'b1, 1'b0, 2};
    tbl[2]  = '{0, 8'd255, 8'd1,   64'd255,   64'd0,   1'b0, 1'b0, 10};
    tbl[3]  = '{0, 8'd7,   8'd255, 64'd0,     64'd7,   1'b0, 1'b1, 10};
    tbl[4]  = '{0, 8'd0,   8'd5,   64'd0,     64'd0,   1'b0, 1'b0, 10};
    tbl[5]  = '{0, 8'd200, 8'd200, 64'd1,     64'd0,   1'b0, 1'b0, 10};
    tbl[6]  = '{1, 8'd1,   8'd3,   64'h005,   64'd1,   1'b0, 1'b1, 14};
    tbl[7]  = '{1, 8'd6,   8'd3,   64'h020,   64'd0,   1'b0, 1'b0, 14};
    tbl[8]  = '{1, 8'd255, 8'd0,   64'hFFF,   64'd255, 1'b1, 1'b0, 2};
    tbl[9]  = '{1, 8'd255, 8'd1,   64'hFF0,   64'd0,   1'b0, 1'b0, 14};
    tbl[10] = '{1, 8'd200, 8'd7,   64'h1C9,   64'd1,   1'b0, 1'b1, 14};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready_a", 64'(ready_a), 64'd1);
    chk("rst_valid_a", 64'(valid_a), 64'd0);
    chk("rst_q_a",     64'(q_a),     64'd0);
    chk("rst_r_a",     64'(r_a),     64'd0);
    chk("rst_dz_a",    64'(dz_a),    64'd0);
    chk("rst_ready_c", 64'(ready_c), 64'd1);
    chk("rst_q_c",     64'(q_c),     64'd0);
`ifdef SEQ_DIV_STICKY_EN
    chk("rst_stk_a",   64'(stk_a),   64'd0);
`endif

    // Fixed vectors
    foreach (tbl[i]) begin
      do_op(tbl[i].inst, 24'(tbl[i].dvd), 24'(tbl[i].dsr), q, r, dz, stk, lat);
      chk($sformatf("vec%0d_q", i),   q,          tbl[i].q);
      chk($sformatf("vec%0d_r", i),   r,          tbl[i].r);
      chk($sformatf("vec%0d_dz", i),  64'(dz),    64'(tbl[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(lat),   64'(tbl[i].lat));
`ifdef SEQ_DIV_STICKY_EN
      chk($sformatf("vec%0d_stk", i), 64'(stk),   64'(tbl[i].stk));
`endif
    end

    // 255/1 with a start pulse mid-iteration, then ack withheld while start keeps pulsing
    dvd8 = 8'd255; dsr8 = 8'd1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!valid_a && lat < 200) begin
      start_a = (lat == 3);
      if (lat == 3) begin dvd8 = 8'd3; dsr8 = 8'd3; end
      @(posedge clk); #1;
      lat++;
    end
    start_a = 1'b0;
    chk("hold_lat", 64'(lat), 64'd10);
    chk("hold_q",   64'(q_a), 64'd255);
    chk("hold_r",   64'(r_a), 64'd0);
    for (int k = 0; k < 5; k++) begin
      start_a = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), 64'(valid_a), 64'd1);
      chk($sformatf("hold%0d_q", k),     64'(q_a),     64'd255);
      chk($sformatf("hold%0d_ready", k), 64'(ready_a), 64'd0);
    end
    // ack and start together: retire only, start not taken
    ack = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; start_a = 1'b0;
    chk("ackstart_ready", 64'(ready_a), 64'd1);
    chk("ackstart_valid", 64'(valid_a), 64'd0);
    @(posedge clk); #1;
    chk("ackstart_idle",  64'(ready_a), 64'd1);
    chk("ackstart_q",     64'(q_a),     64'd255);

    // Reset during the 4th iteration cycle discards the division
    dvd8 = 8'd100; dsr8 = 8'd7; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 64'(ready_a), 64'd1);
    chk("midrst_valid", 64'(valid_a), 64'd0);
    chk("midrst_q",     64'(q_a),     64'd0);
    chk("midrst_r",     64'(r_a),     64'd0);
    chk("midrst_dz",    64'(dz_a),    64'd0);
    repeat (12) @(posedge clk);
    #1 chk("midrst_no_result", 64'(valid_a), 64'd0);
    do_op(0, 24'd9, 24'd4, q, r, dz, stk, lat);
    chk("after_rst_q",   q,        64'd2);
    chk("after_rst_r",   r,        64'd1);
    chk("after_rst_lat", 64'(lat), 64'd10);

    // Randomised 24/24 back-to-back
    for (int i = 0; i < 40; i++) begin
      int sel;
      rd = 24'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rs = '0;
      else if (sel == 1) rs = 24'($urandom_range(1, 15));
      else               rs = 24'($urandom);
      if (i == 0) begin rd = 24'hFFFFFF; rs = 24'd1; end
      if (i == 1) begin rd = 24'd1;      rs = 24'hFFFFFF; end
      if (i == 2) begin rd = 24'hABCDEF; rs = 24'd0; end
      ref_div(24, 24, 64'(rd), 64'(rs), eq, er, edz, estk);
      do_op(2, rd, rs, q, r, dz, stk, lat);
      chk($sformatf("rnd%0d_q", i),   q,        eq);
      chk($sformatf("rnd%0d_r", i),   r,        er);
      chk($sformatf("rnd%0d_dz", i),  64'(dz),  64'(edz));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), edz ? 64'd2 : 64'd50);
`ifdef SEQ_DIV_STICKY_EN
      chk($sformatf("rnd%0d_stk", i), 64'(stk), 64'(estk));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
